// File: rtl/pipe_control_unit_if.sv
// ID-stage handshake and ID/EX control-field bundle between the pipeline
// datapath (master) and the decode/control stage (slave).
interface pipe_control_unit_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        ex_ready;
    logic        flush;
    logic        stall_if;
    logic        ex_valid;
    logic        ex_RegWr;
    logic        ex_ExtOp;
    logic        ex_dREN;
    logic        ex_dWEN;
    logic        ex_halt;
    logic [1:0]  ex_ALUSrc;
    logic [1:0]  ex_RegSel;
    logic [1:0]  ex_PCSrc;
    logic [3:0]  ex_ALUOp;
    logic [4:0]  ex_RegDst;
    logic        halted;

    modport master (
        output instr, instr_valid, ex_ready, flush,
        input  stall_if, ex_valid, ex_RegWr, ex_ExtOp, ex_dREN, ex_dWEN, ex_halt,
               ex_ALUSrc, ex_RegSel, ex_PCSrc, ex_ALUOp, ex_RegDst, halted
    );

    modport slave (
        input  instr, instr_valid, ex_ready, flush,
        output stall_if, ex_valid, ex_RegWr, ex_ExtOp, ex_dREN, ex_dWEN, ex_halt,
               ex_ALUSrc, ex_RegSel, ex_PCSrc, ex_ALUOp, ex_RegDst, halted
    );
endinterface

// File: rtl/pipe_control_unit.sv
// Registered MIPS decode/control stage: decodes the ID instruction into the
// ID/EX control word, inserts load-use bubbles, honours stalls/flushes and halt.
package pipe_control_pkg;
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef struct packed {
        logic       valid;
        logic       regwr;
        logic       extop;
        logic       dren;
        logic       dwen;
        logic       halt;
        logic [1:0] alusrc;
        logic [1:0] regsel;
        logic [1:0] pcsrc;
        aluop_t     aluop;
        logic [4:0] regdst;
    } ctrl_t;

    localparam logic [1:0] SRC_RT = 2'd0, SRC_IMM = 2'd1, SRC_SHAMT = 2'd2;
    localparam logic [1:0] SEL_ALU = 2'd0, SEL_DLOAD = 2'd1, SEL_JAL = 2'd2, SEL_LUI = 2'd3;
    localparam logic [1:0] PC_NORM = 2'd0, PC_BRAN = 2'd1, PC_J = 2'd2, PC_JR = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03,
                           OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                           OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                           OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                           OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08,
                           F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22,
                           F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25,
                           F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A,
                           F_SLTU = 6'h2B;
endpackage

module pipe_control_unit
    import pipe_control_pkg::*;
#(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter logic [5:0]  HALT_OP      = 6'h3F
) (
    input logic                CLK,
    input logic                nRST,
    pipe_control_unit_if.slave bus
);
    localparam int unsigned HIST_W = LOAD_BUBBLES * 5;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t                          state_q, state_d;
    ctrl_t                           ex_q, ex_d;
    logic [LOAD_BUBBLES-1:0]         hist_load_q, hist_load_d;
    logic [LOAD_BUBBLES-1:0][4:0]    hist_dest_q, hist_dest_d;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    ctrl_t      dec;
    logic       use_rs, use_rt;
    logic       hazard;

    assign opcode = bus.instr[31:26];
    assign rs     = bus.instr[25:21];
    assign rt     = bus.instr[20:16];
    assign rd     = bus.instr[15:11];
    assign funct  = bus.instr[5:0];

    // Instruction decode and source-register usage
    always_comb begin
        dec        = '0;
        dec.aluop  = ALU_ADD;
        dec.regdst = rd;
        use_rs     = 1'b1;
        use_rt     = 1'b0;
        if (opcode == HALT_OP) begin
            dec.halt = 1'b1;
            use_rs   = 1'b0;
        end else begin
            case (opcode)
                OP_RTYPE: begin
                    dec.regwr = 1'b1;
                    use_rt    = 1'b1;
                    case (funct)
                        F_SLL:         begin dec.alusrc = SRC_SHAMT; dec.aluop = ALU_SLL; end
                        F_SRL:         begin dec.alusrc = SRC_SHAMT; dec.aluop = ALU_SRL; end
                        F_JR:          begin dec.regwr = 1'b0; dec.pcsrc = PC_JR; use_rt = 1'b0; end
                        F_ADD, F_ADDU: dec.aluop = ALU_ADD;
                        F_SUB, F_SUBU: dec.aluop = ALU_SUB;
                        F_AND:         dec.aluop = ALU_AND;
                        F_OR:          dec.aluop = ALU_OR;
                        F_XOR:         dec.aluop = ALU_XOR;
                        F_NOR:         dec.aluop = ALU_NOR;
                        F_SLT:         dec.aluop = ALU_SLT;
                        F_SLTU:        dec.aluop = ALU_SLTU;
                        default:       ;
                    endcase
                end
                OP_J: begin
                    dec.pcsrc = PC_J;
                    use_rs    = 1'b0;
                end
                OP_JAL: begin
                    dec.pcsrc  = PC_J;
                    dec.regwr  = 1'b1;
                    dec.regsel = SEL_JAL;
                    dec.regdst = 5'd31;
                    use_rs     = 1'b0;
                end
                OP_BEQ, OP_BNE: begin
                    dec.aluop = ALU_SUB;
                    dec.pcsrc = PC_BRAN;
                    use_rt    = 1'b1;
                end
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                    dec.regwr  = 1'b1;
                    dec.alusrc = SRC_IMM;
                    dec.regdst = rt;
                    dec.extop  = (opcode == OP_ADDI) || (opcode == OP_ADDIU) || (opcode == OP_SLTI);
                    case (opcode)
                        OP_SLTI:  dec.aluop = ALU_SLT;
                        OP_SLTIU: dec.aluop = ALU_SLTU;
                        OP_ANDI:  dec.aluop = ALU_AND;
                        OP_ORI:   dec.aluop = ALU_OR;
                        OP_XORI:  dec.aluop = ALU_XOR;
                        default:  dec.aluop = ALU_ADD;
                    endcase
                end
                OP_LUI: begin
                    dec.regwr  = 1'b1;
                    dec.regsel = SEL_LUI;
                    dec.regdst = rt;
                    use_rs     = 1'b0;
                end
                OP_LW: begin
                    dec.regwr  = 1'b1;
                    dec.regsel = SEL_DLOAD;
                    dec.alusrc = SRC_IMM;
                    dec.dren   = 1'b1;
                    dec.regdst = rt;
                end
                OP_SW: begin
                    dec.alusrc = SRC_IMM;
                    dec.dwen   = 1'b1;
                    use_rt     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Load-use check against every in-flight load in the history
    always_comb begin
        logic [LOAD_BUBBLES-1:0]      scan_load;
        logic [LOAD_BUBBLES-1:0][4:0] scan_dest;
        logic                         hit;
        scan_load = hist_load_q;
        scan_dest = hist_dest_q;
        hit       = 1'b0;
        for (int unsigned k = 0; k < LOAD_BUBBLES; k++) begin
            if (scan_load[0] && (scan_dest[0] != 5'd0) &&
                ((use_rs && (scan_dest[0] == rs)) || (use_rt && (scan_dest[0] == rt))))
                hit = 1'b1;
            scan_load = scan_load >> 1;
            scan_dest = scan_dest >> 5;
        end
        hazard = bus.instr_valid && !bus.flush && hit;
    end

    // Next ID/EX word, history shift and RUN/HALTED transitions
    always_comb begin
        state_d     = state_q;
        ex_d        = ex_q;
        hist_load_d = hist_load_q;
        hist_dest_d = hist_dest_q;
        if (bus.ex_ready) begin
            if ((state_q == ST_HALTED) || bus.flush || !bus.instr_valid || hazard) begin
                ex_d = '0;
            end else begin
                ex_d       = dec;
                ex_d.valid = 1'b1;
                if (dec.halt)
                    state_d = ST_HALTED;
            end
            hist_load_d = (hist_load_q << 1) | LOAD_BUBBLES'(ex_d.dren);
            hist_dest_d = (hist_dest_q << 5) | HIST_W'(ex_d.regdst);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_RUN;
            ex_q        <= '0;
            hist_load_q <= '0;
            hist_dest_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            hist_load_q <= hist_load_d;
            hist_dest_q <= hist_dest_d;
        end
    end

    assign bus.stall_if  = (state_q == ST_HALTED) || !bus.ex_ready || hazard;
    assign bus.halted    = (state_q == ST_HALTED);
    assign bus.ex_valid  = ex_q.valid;
    assign bus.ex_RegWr  = ex_q.regwr;
    assign bus.ex_ExtOp  = ex_q.extop;
    assign bus.ex_dREN   = ex_q.dren;
    assign bus.ex_dWEN   = ex_q.dwen;
    assign bus.ex_halt   = ex_q.halt;
    assign bus.ex_ALUSrc = ex_q.alusrc;
    assign bus.ex_RegSel = ex_q.regsel;
    assign bus.ex_PCSrc  = ex_q.pcsrc;
    assign bus.ex_ALUOp  = ex_q.aluop;
    assign bus.ex_RegDst = ex_q.regdst;
endmodule
